// File: rtl/link_burst_if.sv
// Bundles the per-channel link signals between the sender, the emulator and the receiver.
// Latency: none, wiring only.
// Backpressure: none; the emulator drops writes into a full channel and flags overflow.
//
// master : the side that feeds bytes in and watches the bursts (sender/receiver pair or bench)
// slave  : the emulator itself
interface link_burst_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2048
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        flush;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic [NUM_CH*CNT_W-1:0]  fill_count;
    logic [NUM_CH-1:0]        full;
    logic [NUM_CH-1:0]        empty;
    logic [NUM_CH-1:0]        overflow;

    modport master (
        output in_valid, in_data, flush,
        input  out_valid, out_data, fill_count, full, empty, overflow
    );

    modport slave (
        input  in_valid, in_data, flush,
        output out_valid, out_data, fill_count, full, empty, overflow
    );
endinterface

// File: rtl/link_burst_emu.sv
// Multi-channel link emulator: buffers each channel's byte stream and releases it as one gap-free burst.
// Latency: threshold byte accepted at E0 -> DRAIN at E1 -> first out_valid after E2; timeout/flush similar.
// Backpressure: none; writes into a full channel are dropped and set the sticky overflow flag.
//
// Ports: clk, reset (sync, active-low); lnk (slave modport) carries per-channel
//   in_valid/in_data/flush inputs and out_valid/out_data/fill_count/full/empty/overflow outputs.
module link_burst_emu #(
    parameter int NUM_CH       = 2,
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 2048,
    parameter int BURST_THRESH = 16,
    parameter int TIMEOUT      = 64
) (
    input  logic         clk,
    input  logic         reset,
    link_burst_if.slave  lnk
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int AW    = $clog2(DEPTH);
    // Timer saturates at TIMEOUT so a stalled full channel cannot wrap it back into the trigger value.
    localparam int TMR_W = $clog2(TIMEOUT + 2);

    typedef enum logic {ST_IDLE, ST_DRAIN} state_e;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DATA_W-1:0] mem [DEPTH];

        state_e            state_q, state_d;
        logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0]  count_q, count_d, drain_len_q, drain_len_d;
        logic [TMR_W-1:0]  timer_q, timer_d;
        logic              out_valid_q, out_valid_d, overflow_q, overflow_d;
        logic [DATA_W-1:0] out_data_q, out_data_d;

        logic              wr_vld, flush_req, full_w, empty_w, wr_acc, pop, tmo_hit, trigger;
        logic [DATA_W-1:0] wr_dat;

        assign wr_vld    = lnk.in_valid[k];
        assign wr_dat    = lnk.in_data[k*DATA_W +: DATA_W];
        assign flush_req = lnk.flush[k];

        assign full_w  = (count_q == CNT_W'(DEPTH));
        assign empty_w = (count_q == '0);
        // Full is judged on the pre-edge count, so a same-cycle pop never rescues a write.
        assign wr_acc  = wr_vld && !full_w;
        // drain_len never exceeds the count at DRAIN entry, so DRAIN always has a head to pop.
        assign pop     = (state_q == ST_DRAIN);
        // A write arriving in the expiry cycle restarts the idle period instead of releasing.
        assign tmo_hit = (TIMEOUT != 0) && (int'(timer_q) == TIMEOUT - 1) && !wr_vld;
        assign trigger = !empty_w && ((int'(count_q) >= BURST_THRESH) || flush_req || tmo_hit);

        // State register
        always_ff @(posedge clk) begin
            if (!reset) begin
                state_q     <= ST_IDLE;
                drain_len_q <= '0;
                timer_q     <= '0;
            end else begin
                state_q     <= state_d;
                drain_len_q <= drain_len_d;
                timer_q     <= timer_d;
            end
        end

        // Next-state logic
        always_comb begin
            state_d     = state_q;
            drain_len_d = drain_len_q;
            timer_d     = timer_q;
            case (state_q)
                ST_IDLE: begin
                    if (wr_acc || empty_w) begin
                        timer_d = '0;
                    end else if (int'(timer_q) < TIMEOUT) begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                    if (trigger) begin
                        state_d     = ST_DRAIN;
                        drain_len_d = count_q;   // same-cycle write belongs to the next burst
                        timer_d     = '0;
                    end
                end
                ST_DRAIN: begin
                    drain_len_d = drain_len_q - CNT_W'(1);
                    timer_d     = '0;
                    if (drain_len_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end

        // Datapath / outputs
        always_comb begin
            wr_ptr_d = wr_ptr_q + AW'(wr_acc);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            count_d  = count_q;
            if (wr_acc) count_d = count_d + CNT_W'(1);
            if (pop)    count_d = count_d - CNT_W'(1);
            out_valid_d = pop;
            out_data_d  = pop ? mem[rd_ptr_q] : out_data_q;
            overflow_d  = overflow_q | (wr_vld & full_w);
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                count_q     <= '0;
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
                overflow_q  <= 1'b0;
            end else begin
                wr_ptr_q    <= wr_ptr_d;
                rd_ptr_q    <= rd_ptr_d;
                count_q     <= count_d;
                out_valid_q <= out_valid_d;
                out_data_q  <= out_data_d;
                overflow_q  <= overflow_d;
            end
        end

        // Storage is not reset; the pointers alone define what is valid.
        always_ff @(posedge clk) begin
            if (reset && wr_acc) begin
                mem[wr_ptr_q] <= wr_dat;
            end
        end

        assign lnk.out_valid[k]                   = out_valid_q;
        assign lnk.out_data[k*DATA_W +: DATA_W]   = out_data_q;
        assign lnk.fill_count[k*CNT_W +: CNT_W]   = count_q;
        assign lnk.full[k]                        = full_w;
        assign lnk.empty[k]                       = empty_w;
        assign lnk.overflow[k]                    = overflow_q;
    end
endmodule
